// File: rtl/opram_fetch_pkg.sv
// Shared types and helpers for the opcode RAM fetch unit.
// Holds the fetch FSM state type and the address-width helper.
package opram_fetch_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_STREAM,
        ST_HALT
    } state_e;

    function automatic int clog2(input int n);
        int w = 0;
        while ((1 << w) < n) w++;
        return w;
    endfunction

endpackage

// File: rtl/opram_mem.sv
// Portable single-port synchronous opcode RAM, 1-cycle read latency.
// A write owns the port; reads happen on every non-write cycle.
module opram_mem #(
    parameter int OP_W   = 8,
    parameter int DEPTH  = 16,
    parameter int ADDR_W = 4
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [OP_W-1:0]   din,
    output logic [OP_W-1:0]   dout
);

    logic [OP_W-1:0] r_mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            r_mem[addr] <= din;
        end else begin
            dout <= r_mem[addr];
        end
    end

endmodule

// File: rtl/opram_fetch.sv
// Opcode RAM with PC-driven fetch engine streaming {op, pc} to the decoder
// through a 2-entry buffer; supports jumps, load-port writes and wrap/halt.
module opram_fetch
    import opram_fetch_pkg::*;
#(
    parameter int  OP_W   = 8,
    parameter int  DEPTH  = 16,
    parameter int  WRAP   = 1,
    localparam int ADDR_W = clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load_en,
    input  logic [ADDR_W-1:0] load_addr,
    input  logic [OP_W-1:0]   load_data,
    input  logic              run,
    input  logic              jump,
    input  logic [ADDR_W-1:0] jump_addr,
    output logic              op_valid,
    input  logic              op_ready,
    output logic [OP_W-1:0]   op,
    output logic [ADDR_W-1:0] op_pc,
    output logic              halted
);

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

    state_e            r_state, w_state_nxt;
    logic [ADDR_W-1:0] r_pc, r_rd_pc, w_addr;
    logic              r_rd_vld;
    logic [OP_W-1:0]   r_fifo_op [2];
    logic [ADDR_W-1:0] r_fifo_pc [2];
    logic              r_rptr, r_wptr;
    logic [1:0]        r_count;
    logic [2:0]        w_occ;
    logic              w_pop, w_push, w_issue;
    logic [OP_W-1:0]   w_rdata;

    assign op_valid = (r_count != 2'd0);
    assign op       = r_fifo_op[r_rptr];
    assign op_pc    = r_fifo_pc[r_rptr];
    assign halted   = (r_state == ST_HALT);

    assign w_pop  = op_valid & op_ready;
    assign w_push = r_rd_vld & ~jump;
    // Occupancy seen by the issue check credits this cycle's pop so a
    // streaming decoder with ready held high gets one op every cycle.
    assign w_occ  = {1'b0, r_count} - {2'b0, w_pop} + {2'b0, r_rd_vld};
    assign w_addr = load_en ? load_addr : r_pc;

    // Issue is allowed in the first run cycle out of IDLE so the first op
    // lands two cycles after run rises.
    always_comb begin
        w_state_nxt = r_state;
        w_issue     = 1'b0;
        if (jump) begin
            w_state_nxt = run ? ST_STREAM : ST_IDLE;
        end else if (r_state != ST_HALT) begin
            w_issue = run & ~load_en & (w_occ < 3'd2);
            if (w_issue && (r_pc == LAST_ADDR) && (WRAP == 0)) begin
                w_state_nxt = ST_HALT;
            end else begin
                w_state_nxt = run ? ST_STREAM : ST_IDLE;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_pc     <= '0;
            r_rd_pc  <= '0;
            r_rd_vld <= 1'b0;
        end else if (jump) begin
            r_pc     <= jump_addr;
            r_rd_vld <= 1'b0;
        end else begin
            r_rd_vld <= w_issue;
            if (w_issue) begin
                r_pc    <= r_pc + 1'b1;
                r_rd_pc <= r_pc;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int unsigned i = 0; i < 2; i++) begin
                r_fifo_op[i] <= '0;
                r_fifo_pc[i] <= '0;
            end
            r_rptr  <= 1'b0;
            r_wptr  <= 1'b0;
            r_count <= '0;
        end else if (jump) begin
            r_rptr  <= 1'b0;
            r_wptr  <= 1'b0;
            r_count <= '0;
        end else begin
            if (w_push) begin
                r_fifo_op[r_wptr] <= w_rdata;
                r_fifo_pc[r_wptr] <= r_rd_pc;
                r_wptr            <= ~r_wptr;
            end
            if (w_pop) begin
                r_rptr <= ~r_rptr;
            end
            r_count <= r_count + {1'b0, w_push} - {1'b0, w_pop};
        end
    end

    opram_mem #(
        .OP_W   (OP_W),
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_mem (
        .clk  (clk),
        .we   (load_en),
        .addr (w_addr),
        .din  (load_data),
        .dout (w_rdata)
    );

endmodule
